hilo_muldiv_unit: RTL

- Execute-stage consumer of the 5-bit ALU control code for the multi-cycle operations: MULT, MULTU, DIV, DIVU.
- Owns the architectural HI/LO registers and runs a fixed-latency multiply and a radix-2 iterative divide.
- Raises a stall to the pipeline while an operation is in flight.
- Also services MTHI/MTLO writes. HI/LO reads are combinational from the registers.

---
 rtl/hilo_muldiv_unit_pkg.sv | 28 ++
 rtl/hilo_muldiv_unit_div_radix2.sv | 114 +++++++++++
 rtl/hilo_muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared ALU control codes and helpers for the HI/LO multiply/divide unit.
// Only the four multi-cycle codes are decoded by hilo_muldiv_unit. The other
// codes are listed so that callers and benches can name them.
package hilo_muldiv_unit_pkg;

    localparam int unsigned ALU_CTRL_W = 5;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ADD_CONTROL   = 5'b00010;
    localparam alu_ctrl_t MULT_CONTROL  = 5'b10100;
    localparam alu_ctrl_t MULTU_CONTROL = 5'b10101;
    localparam alu_ctrl_t DIV_CONTROL   = 5'b10110;
    localparam alu_ctrl_t DIVU_CONTROL  = 5'b10111;

    function automatic logic is_mul_code(input alu_ctrl_t c);
        return (c == MULT_CONTROL) || (c == MULTU_CONTROL);
    endfunction

    function automatic logic is_div_code(input alu_ctrl_t c);
        return (c == DIV_CONTROL) || (c == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_code(input alu_ctrl_t c);
        return (c == MULT_CONTROL) || (c == DIV_CONTROL);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// Iterative restoring divider producing one quotient bit per cycle.
//   clk, resetn      : clock, asynchronous active-low reset
//   start            : latch operands and begin DATA_W iterations
//   signed_op        : treat operands as two's complement
//   dividend/divisor : operands, sampled on start
//   cancel           : abandon the current division
//   busy             : iterations in progress
//   done             : one-cycle pulse in the cycle after the last iteration
//   quotient         : sign-corrected quotient (all ones on divide by zero)
//   remainder        : sign-corrected remainder (takes the dividend's sign)
module div_radix2
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              dz_q;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;

    always_comb begin
        a_mag = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
        b_mag = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;
    end

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[DATA_W]) begin
            rem_nx = trial[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nx = shifted[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cancel) begin
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                rem_q   <= '0;
                quo_q   <= a_mag;
                dvs_q   <= b_mag;
                q_neg_q <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                r_neg_q <= signed_op && dividend[DATA_W-1];
                dz_q    <= (divisor == '0);
            end else if (busy_q) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Divide by zero leaves |dividend| in the remainder; re-applying the
    // dividend's sign restores the original dividend, so only the quotient
    // needs overriding.
    always_comb begin
        quotient  = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        remainder = r_neg_q ? -rem_q : rem_q;
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner for MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
//   clk, resetn     : clock, asynchronous active-low reset
//   alu_control     : operation code; only the four mul/div codes are acted on
//   start           : execute stage holds a valid instruction
//   src_a, src_b    : rs / rt operands
//   cancel          : flush; abandons any in-flight operation
//   hi_we, lo_we    : MTHI / MTLO write enables, hilo_wdata is the data
//   stall           : hold the pipeline (combinational)
//   done            : one-cycle pulse in the completion cycle
//   hi, lo          : architectural HI/LO registers
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [4:0]        alu_control,
    input  logic              start,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               mul_last;
    logic               complete;

    logic [DATA_W-1:0]   ma_q, mb_q;
    logic                msgn_q;
    logic [2*DATA_W-1:0] ea, eb, prod0, mul_res;

    logic               div_busy, div_done;
    logic [DATA_W-1:0]  div_quo, div_rem;
    logic [DATA_W-1:0]  res_hi, res_lo;

    assign accept = (state_q == ST_IDLE) && start && !cancel &&
                    (is_mul_code(alu_control) || is_div_code(alu_control));

    assign mul_last = (state_q == ST_MUL) && (cnt_q == CNT_W'(MUL_LAT - 1));
    assign complete = (mul_last || (state_q == ST_FIX)) && !cancel;

    assign stall = accept ||
                   ((state_q != ST_IDLE) && !mul_last && (state_q != ST_FIX) && !cancel);
    assign done  = complete;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul_code(alu_control) ? ST_MUL : ST_DIV;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_last) state_d = ST_IDLE;
            end
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiply: operand latch is the first of MUL_LAT register stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ma_q   <= '0;
            mb_q   <= '0;
            msgn_q <= 1'b0;
        end else if (accept && is_mul_code(alu_control)) begin
            ma_q   <= src_a;
            mb_q   <= src_b;
            msgn_q <= is_signed_code(alu_control);
        end
    end

    // A 2*DATA_W product of sign- or zero-extended operands is exact for
    // both signednesses.
    always_comb begin
        ea    = msgn_q ? {{DATA_W{ma_q[DATA_W-1]}}, ma_q} : {{DATA_W{1'b0}}, ma_q};
        eb    = msgn_q ? {{DATA_W{mb_q[DATA_W-1]}}, mb_q} : {{DATA_W{1'b0}}, mb_q};
        prod0 = ea * eb;
    end

    if (MUL_LAT == 1) begin : g_mul_lat1
        assign mul_res = prod0;
    end else begin : g_mul_pipe
        logic [2*DATA_W-1:0] pipe_q [MUL_LAT-1];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int unsigned i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= prod0;
                for (int unsigned i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign mul_res = pipe_q[MUL_LAT-2];
    end

    div_radix2 #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept && is_div_code(alu_control)),
        .signed_op (is_signed_code(alu_control)),
        .dividend  (src_a),
        .divisor   (src_b),
        .cancel    (cancel),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        if (state_q == ST_MUL) begin
            res_hi = mul_res[2*DATA_W-1:DATA_W];
            res_lo = mul_res[DATA_W-1:0];
        end else begin
            res_hi = div_rem;
            res_lo = div_quo;
        end
    end

    // Completion result takes priority over a same-cycle MTHI/MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (complete) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (hi_we) hi <= hilo_wdata;
            if (lo_we) lo <= hilo_wdata;
        end
    end

    a_no_write_while_busy: assert property (
        @(posedge clk) disable iff (!resetn)
        !((hi_we || lo_we) && (state_q != ST_IDLE) && !complete)
    ) else $error("MTHI/MTLO write while mul/div in flight");

    a_div_core_busy: assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == ST_DIV) |-> div_busy
    ) else $error("divider core idle during DIV state");

    a_div_core_done: assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == ST_FIX) |-> div_done
    ) else $error("divider core result not ready in FIX state");

endmodule
